sos_sequencer: RTL
==================

Name: sos_sequencer

Overview:
- Control and cascade block for the time-multiplexed IIR filter.
- Accepts one input sample per filter period through a valid/ready handshake.
- Steps one shared SOS datapath through No_SOS sections, one section per cycle, and feeds each section's output back as the next section's input.
- Drives the section index and write strobe that the per-section state store consumes, then presents the final cascade output through a valid/ready handshake.

Parameters:
- BW, 9, sample word width (signed) on all data ports.
- No_SOS, 4, number of cascaded second-order sections; legal range 1..31.
- IDX_W, 5, width of the section index; must satisfy 2**IDX_W > No_SOS.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- in_valid  input  1  input sample offered.
- in_ready  output  1  block can accept a sample.
- in_data  input  BW  signed input sample.
- sec_in  output  BW  signed sample presented to the SOS datapath.
- sec_idx  output  IDX_W  active section number; selects coefficients and the state slot.
- sec_valid  output  1  datapath cycle active.
- state_we  output  1  write strobe for the per-section state store.
- sec_out  input  BW  signed datapath result for sec_in/sec_idx, combinational in the same cycle.
- out_valid  output  1  filtered sample available.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  BW  signed filtered sample.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (RESET==0 at a rising edge) applies regardless of state:
  - state=IDLE, idx=0, cascade register=0, out_data=0, out_valid=0.
  - Outputs in reset: in_ready=0, sec_valid=0, state_we=0, busy=0.
  - A transfer in progress is discarded and no output is produced.
- FSM states: IDLE, RUN, DONE. Registered state; outputs decode from state.
- IDLE:
  - in_ready=1, sec_valid=0, state_we=0.
  - When in_valid&&in_ready at an edge: cascade<=in_data, idx<=0, go to RUN.
- RUN:
  - in_ready=0, sec_valid=1, state_we=1, sec_idx=idx, sec_in=cascade.
  - Each edge: cascade<=sec_out.
  - If idx!=No_SOS-1: idx<=idx+1, stay in RUN.
  - If idx==No_SOS-1: idx<=0, out_data<=sec_out, out_valid<=1, go to DONE.
  - RUN lasts exactly No_SOS cycles. Each index 0..No_SOS-1 is issued exactly once, in ascending order, with no gaps.
- DONE:
  - in_ready=0, sec_valid=0, state_we=0.
  - out_data and out_valid are held stable while out_ready=0, indefinitely.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
- Latency: input accepted at edge T0; out_valid rises at edge T0+No_SOS.
- Throughput: minimum period between accepted samples is No_SOS+2 cycles with out_ready tied high.
- Back-pressure never corrupts the section state, because state_we is low outside RUN.
- Index wrap: idx never exceeds No_SOS-1. With No_SOS=1, RUN lasts one cycle at idx 0.
- in_valid asserted in RUN or DONE is ignored (in_ready=0). in_data need not be held stable except during the accepting cycle.
- Arithmetic: no arithmetic in this block. sec_out is captured verbatim at BW bits; saturation and rounding belong to the datapath.
- sec_in outside RUN equals the cascade register; it is don't-care for consumers.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default BW / No_SOS / IDX_W constants shared with the state store and datapath.
- One natural sub-module: sos_idx_counter.
  - Ports: clear, enable, terminal-count output at No_SOS-1.
  - Registered IDX_W-bit count.
- The FSM and cascade register stay in the top level.

Test Plan:
- Bench datapath model: sec_out=sec_in+sec_idx+1.
- Single sample, No_SOS=4: in_data=10, out_ready=1 → sec_idx sequence 0,1,2,3 with state_we high four cycles. out_valid rises 4 edges after acceptance with out_data=20; in_ready returns after 6 cycles total.
- Back-pressure: out_ready=0 for 5 cycles after out_valid → out_data=20 held; in_ready=0, state_we=0 throughout. Raising out_ready gives one transfer, then IDLE.
- Back-to-back, in_valid held high: inputs 10 then -7 → outputs 20 then 3. Accept edges exactly 6 cycles apart; no index skipped or repeated.
- Reset mid-RUN: drop RESET at idx=2 → next edge gives IDLE, out_valid=0, idx=0, state_we=0. The following sample 0 yields out_data=10 with no residue from the aborted run.
- No_SOS=1 build: in_data=-128 (BW=9) → one RUN cycle at idx 0; out_data=-127 at T0+1.
- Ignored input: pulse in_valid with in_data=99 during RUN → no effect on cascade or output; only the originally accepted sample is processed.

Source files
------------

// File: rtl/sos_sequencer_pkg.sv
// sos_sequencer_pkg: FSM encoding and default widths shared by the IIR sequencer, state store and datapath.
package sos_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int BW_DEF     = 9;
    localparam int NO_SOS_DEF = 4;
    localparam int IDX_W_DEF  = 5;
endpackage

// File: rtl/sos_idx_counter.sv
// sos_idx_counter: section index counter, wraps to zero after the last section.
module sos_idx_counter
    import sos_sequencer_pkg::*;
#(
    parameter int No_SOS = NO_SOS_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] count,
    output logic             tc
);
    assign tc = count == IDX_W'(No_SOS - 1);
    always_ff @(posedge CLK) begin
        if (!RESET || clear)
            count <= '0;
        else if (enable)
            count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/sos_sequencer.sv
// sos_sequencer: steps one shared SOS datapath through No_SOS cascaded sections per accepted sample.
module sos_sequencer
    import sos_sequencer_pkg::*;
#(
    parameter int BW     = BW_DEF,
    parameter int No_SOS = NO_SOS_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [BW-1:0] in_data,
    output logic signed [BW-1:0] sec_in,
    output logic [IDX_W-1:0]     sec_idx,
    output logic                 sec_valid,
    output logic                 state_we,
    input  logic signed [BW-1:0] sec_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [BW-1:0] out_data,
    output logic                 busy
);
    state_t               state, state_nx;
    logic signed [BW-1:0] cascade;
    logic                 last;

    // Index is held at zero outside RUN, so every run starts at section 0.
    sos_idx_counter #(.No_SOS(No_SOS), .IDX_W(IDX_W)) u_idx (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (state != RUN),
        .enable (state == RUN),
        .count  (sec_idx),
        .tc     (last)
    );

    always_ff @(posedge CLK) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
    end

    // Outputs are forced inactive while reset is asserted.
    always_comb begin
        in_ready  = RESET && state == IDLE;
        sec_valid = RESET && state == RUN;
        state_we  = RESET && state == RUN;
        busy      = RESET && (state == RUN || state == DONE);
        sec_in    = cascade;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cascade   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && in_valid)
                cascade <= in_data;
            if (state == RUN)
                cascade <= sec_out;
            if (state == RUN && last) begin
                out_data  <= sec_out;
                out_valid <= 1'b1;
            end
            if (state == DONE && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule
